// File: rtl/apb_timer.sv
// apb_timer: prescaled 32-bit timer/compare slave on the APB side.
// Ports: clock/nRst, HSEL/HADDR/HWRITE/HBE/HWDATA in; HRDATA/HREADY/interrupt out.
module apb_timer #(
  parameter int ADDR_WIDTH     = 32,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  nRst,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [3:0]            HBE,
  input  logic [31:0]           HWDATA,
  output logic [31:0]           HRDATA,
  output logic                  HREADY,
  output logic                  interrupt
);

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    RELEASE
  } state_t;

  state_t state;
  logic   ready;
  logic [2:0]  a_off;
  logic        a_wr;
  logic [31:0] a_wdata;
  logic [3:0]  a_be;

  logic en;
  logic irq_en;
  logic auto_rl;
  logic match;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic [PRESCALE_WIDTH-1:0] pcnt;
  logic [31:0] count;
  logic [31:0] compare;

  logic [31:0] rdata;
  logic [31:0] merged;
  logic        wr_now;
  logic        tick;
  logic sel_ctrl, sel_pre, sel_cnt, sel_cmp, sel_stat;

  logic unused;
  assign unused = ^{HADDR[ADDR_WIDTH-1:5], HADDR[1:0]};

  always_ff @(posedge clock or negedge nRst) begin
    if (!nRst) begin
      state   <= IDLE;
      ready   <= 1'b0;
      a_off   <= '0;
      a_wr    <= 1'b0;
      a_wdata <= '0;
      a_be    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (HSEL) begin
            a_off   <= HADDR[4:2];
            a_wr    <= HWRITE;
            a_wdata <= HWDATA;
            a_be    <= HBE;
            ready   <= 1'b1;
            state   <= ACK;
          end
        end
        ACK: begin
          ready <= 1'b0;
          state <= RELEASE;
        end
        RELEASE: begin
          if (!HSEL) state <= IDLE;
        end
        default: begin
          ready <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign sel_ctrl = (a_off == 3'd0);
  assign sel_pre  = (a_off == 3'd1);
  assign sel_cnt  = (a_off == 3'd2);
  assign sel_cmp  = (a_off == 3'd3);
  assign sel_stat = (a_off == 3'd4);

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_ctrl: rdata = {29'b0, auto_rl, irq_en, en};
      sel_pre:  rdata = 32'(prescale);
      sel_cnt:  rdata = count;
      sel_cmp:  rdata = compare;
      sel_stat: rdata = {31'b0, match};
      default:  rdata = '0;
    endcase
  end

  // Byte-lane merge of write data over the addressed register's value.
  always_comb begin
    merged = rdata;
    for (int i = 0; i < 4; i++) begin
      if (a_be[i]) merged[i*8 +: 8] = a_wdata[i*8 +: 8];
    end
  end

  assign wr_now = ready && a_wr;
  assign tick   = en && (pcnt == prescale);

  // Statement order sets priority: W1C < match set, tick < COUNT write.
  always_ff @(posedge clock or negedge nRst) begin
    if (!nRst) begin
      en       <= 1'b0;
      irq_en   <= 1'b0;
      auto_rl  <= 1'b0;
      match    <= 1'b0;
      prescale <= '0;
      pcnt     <= '0;
      count    <= '0;
      compare  <= '0;
    end else begin
      if (!en || tick) pcnt <= '0;
      else pcnt <= pcnt + 1'b1;

      if (wr_now && sel_stat && a_be[0] && a_wdata[0])
        match <= 1'b0;

      if (tick) begin
        if (count == compare) begin
          match <= 1'b1;
          count <= auto_rl ? 32'd0 : count + 32'd1;
        end else begin
          count <= count + 32'd1;
        end
      end

      if (wr_now && sel_ctrl) begin
        en      <= merged[0];
        irq_en  <= merged[1];
        auto_rl <= merged[2];
      end
      if (wr_now && sel_pre) prescale <= merged[PRESCALE_WIDTH-1:0];
      if (wr_now && sel_cnt) count <= merged;
      if (wr_now && sel_cmp) compare <= merged;
    end
  end

  assign HREADY    = ready;
  assign HRDATA    = ready ? rdata : 32'd0;
  assign interrupt = match & irq_en;

endmodule

// File: tb/tb_apb_timer.sv
// tb_apb_timer: self-checking bench for apb_timer.
// Table-driven register vectors plus timed timer sequences.
module tb_apb_timer;

  logic        clock;
  logic        nRst;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [3:0]  HBE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        interrupt;

  apb_timer #(.ADDR_WIDTH(32), .PRESCALE_WIDTH(16)) dut (
    .clock(clock),
    .nRst(nRst),
    .HSEL(HSEL),
    .HADDR(HADDR),
    .HWRITE(HWRITE),
    .HBE(HBE),
    .HWDATA(HWDATA),
    .HRDATA(HRDATA),
    .HREADY(HREADY),
    .interrupt(interrupt)
  );

  localparam logic [4:0] O_CTRL = 5'h00;
  localparam logic [4:0] O_PRE  = 5'h04;
  localparam logic [4:0] O_CNT  = 5'h08;
  localparam logic [4:0] O_CMP  = 5'h0C;
  localparam logic [4:0] O_STAT = 5'h10;

  typedef struct {
    bit          wr;
    logic [4:0]  off;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    string       nm;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   checks;
  int   errors;
  int   cyc;
  int   commit;
  int   c0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) step();
  endtask

  // Access whose ACK edge lands on cycle t (t=0: as soon as possible).
  task automatic access(input int t, input bit wr, input logic [4:0] off,
                        input logic [31:0] d, input logic [3:0] be,
                        input logic [31:0] exp, input string nm);
    int  n;
    bit  seen;
    sb_t e;
    if (t > 0) begin
      if (cyc > t - 1) begin
        checks++;
        errors++;
        $display("FAIL %s_sched: cycle %0d past %0d", nm, cyc, t - 1);
      end
      wait_to(t - 1);
    end
    if (!wr) sb.push_back('{exp, nm});
    HSEL   = 1'b1;
    HADDR  = 32'(off);
    HWRITE = wr;
    HWDATA = d;
    HBE    = be;
    #1;
    chk({nm, "_idle_rdy"}, 32'(HREADY), 32'd0);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 4) begin
      step();
      n++;
      if (HREADY) seen = 1'b1;
    end
    chk({nm, "_lat"}, 32'(n), 32'd1);
    if (seen) commit = cyc + 1;
    if (!wr) begin
      e = sb.pop_front();
      if (seen) chk(e.nm, HRDATA, e.exp);
    end
    HSEL   = 1'b0;
    HWRITE = 1'b0;
    step();
    chk({nm, "_pulse"}, {HREADY, HRDATA}, 33'd0);
    step();
  endtask

  task automatic wr(input int t, input logic [4:0] off, input logic [31:0] d,
                    input logic [3:0] be, input string nm);
    access(t, 1'b1, off, d, be, 32'd0, nm);
  endtask

  task automatic rd(input int t, input logic [4:0] off,
                    input logic [31:0] exp, input string nm);
    access(t, 1'b0, off, 32'd0, 4'h0, exp, nm);
  endtask

  task automatic do_reset();
    HSEL = 1'b0;
    nRst = 1'b0;
    step();
    step();
    nRst = 1'b1;
    step();
  endtask

  initial begin
    int pulses;
    int hc;
    checks = 0;
    errors = 0;
    HSEL   = 1'b0;
    HADDR  = '0;
    HWRITE = 1'b0;
    HBE    = '0;
    HWDATA = '0;
    nRst   = 1'b0;
    #1;
    chk("rst_outs", {HREADY, HRDATA, interrupt}, 34'd0);
    do_reset();
    chk("rst_outs2", {HREADY, HRDATA, interrupt}, 34'd0);

    for (int i = 0; i < 8; i++)
      vecs.push_back('{1'b0, 5'(i * 4), 32'd0, 4'h0, 32'd0});
    vecs.push_back('{1'b1, O_CTRL, 32'hFFFF_FFF6, 4'hF, 32'd0});
    vecs.push_back('{1'b0, O_CTRL, 32'd0, 4'h0, 32'h0000_0006});
    vecs.push_back('{1'b1, O_PRE, 32'hABCD_1234, 4'hF, 32'd0});
    vecs.push_back('{1'b0, O_PRE, 32'd0, 4'h0, 32'h0000_1234});
    vecs.push_back('{1'b1, O_CMP, 32'hCAFE_BABE, 4'hF, 32'd0});
    vecs.push_back('{1'b0, O_CMP, 32'd0, 4'h0, 32'hCAFE_BABE});
    vecs.push_back('{1'b1, O_CMP, 32'h1122_3344, 4'b1001, 32'd0});
    vecs.push_back('{1'b0, O_CMP, 32'd0, 4'h0, 32'h11FE_BA44});
    vecs.push_back('{1'b1, O_CNT, 32'h1234_5678, 4'b0010, 32'd0});
    vecs.push_back('{1'b0, O_CNT, 32'd0, 4'h0, 32'h0000_5600});
    vecs.push_back('{1'b1, 5'h14, 32'hFFFF_FFFF, 4'hF, 32'd0});
    vecs.push_back('{1'b0, 5'h14, 32'd0, 4'h0, 32'd0});
    vecs.push_back('{1'b1, O_STAT, 32'h1, 4'hF, 32'd0});
    vecs.push_back('{1'b0, O_STAT, 32'd0, 4'h0, 32'd0});
    foreach (vecs[i])
      access(0, vecs[i].wr, vecs[i].off, vecs[i].d, vecs[i].be,
             vecs[i].exp, $sformatf("vec%0d", i));
    chk("tbl_irq", 32'(interrupt), 32'd0);

    // Compare match without reload: tick every 4 cycles.
    do_reset();
    wr(0, O_PRE, 32'd3, 4'hF, "m_pre");
    wr(0, O_CMP, 32'd5, 4'hF, "m_cmp");
    wr(0, O_CTRL, 32'h3, 4'hF, "m_ctrl");
    c0 = commit;
    rd(c0 + 3, O_CNT, 32'd0, "m_cnt3");
    rd(c0 + 7, O_CNT, 32'd1, "m_cnt7");
    rd(c0 + 12, O_CNT, 32'd3, "m_cnt12");
    rd(c0 + 20, O_STAT, 32'd0, "m_stat20");
    wait_to(c0 + 23);
    chk("m_irq23", 32'(interrupt), 32'd0);
    wait_to(c0 + 24);
    chk("m_irq24", 32'(interrupt), 32'd1);
    rd(c0 + 26, O_CNT, 32'd6, "m_cnt26");
    rd(c0 + 30, O_STAT, 32'd1, "m_stat30");

    // Auto-reload: 0..5 repeating, W1C needs HBE[0].
    do_reset();
    wr(0, O_PRE, 32'd3, 4'hF, "a_pre");
    wr(0, O_CMP, 32'd5, 4'hF, "a_cmp");
    wr(0, O_CTRL, 32'h7, 4'hF, "a_ctrl");
    c0 = commit;
    rd(c0 + 23, O_CNT, 32'd5, "a_cnt23");
    rd(c0 + 27, O_CNT, 32'd0, "a_cnt27");
    rd(c0 + 30, O_STAT, 32'd1, "a_stat30");
    chk("a_irq32", 32'(interrupt), 32'd1);
    wr(c0 + 33, O_STAT, 32'h1, 4'b1110, "a_w1c_nobe");
    chk("a_irq35", 32'(interrupt), 32'd1);
    rd(c0 + 37, O_STAT, 32'd1, "a_stat37");
    wr(c0 + 40, O_STAT, 32'h1, 4'b0001, "a_w1c");
    chk("a_irq42", 32'(interrupt), 32'd0);
    rd(c0 + 43, O_STAT, 32'd0, "a_stat43");
    rd(c0 + 46, O_CNT, 32'd5, "a_cnt46");
    rd(c0 + 49, O_STAT, 32'd1, "a_stat49");
    rd(c0 + 52, O_CNT, 32'd1, "a_cnt52");

    // 32-bit wrap without a match flag.
    do_reset();
    wr(0, O_PRE, 32'd3, 4'hF, "w_pre");
    wr(0, O_CMP, 32'h10, 4'hF, "w_cmp");
    wr(0, O_CNT, 32'hFFFF_FFFE, 4'hF, "w_cnt");
    wr(0, O_CTRL, 32'h1, 4'hF, "w_ctrl");
    c0 = commit;
    rd(c0 + 5, O_CNT, 32'hFFFF_FFFF, "w_cnt5");
    rd(c0 + 9, O_CNT, 32'h0, "w_cnt9");
    rd(c0 + 12, O_STAT, 32'd0, "w_stat12");

    // PRESCALE=0: every cycle ticks, so a COUNT write collides with one.
    do_reset();
    wr(0, O_CTRL, 32'h1, 4'hF, "t_ctrl");
    c0 = commit;
    rd(c0 + 5, O_CNT, 32'd5, "t_cnt5");
    wr(0, O_CNT, 32'hA5A5_A5A5, 4'hF, "t_wcnt");
    rd(commit + 2, O_CNT, 32'hA5A5_A5A7, "t_cnt_win");

    // Select held high for 5 cycles: one pulse, one update.
    HSEL   = 1'b1;
    HADDR  = 32'(O_CNT);
    HWRITE = 1'b1;
    HWDATA = 32'h100;
    HBE    = 4'hF;
    pulses = 0;
    hc     = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (HREADY) begin
        pulses++;
        hc = cyc;
      end
    end
    HSEL   = 1'b0;
    HWRITE = 1'b0;
    chk("h_pulses", 32'(pulses), 32'd1);
    step();
    step();
    rd(hc + 7, O_CNT, 32'h106, "h_cnt");

    // Reset asserted during ACK aborts the write.
    do_reset();
    HSEL   = 1'b1;
    HADDR  = 32'(O_CMP);
    HWRITE = 1'b1;
    HWDATA = 32'hDEAD;
    HBE    = 4'hF;
    step();
    chk("r_ack", 32'(HREADY), 32'd1);
    #1;
    nRst = 1'b0;
    #1;
    chk("r_abort", {HREADY, HRDATA}, 33'd0);
    HSEL   = 1'b0;
    HWRITE = 1'b0;
    step();
    step();
    nRst = 1'b1;
    step();
    rd(0, O_CMP, 32'd0, "r_cmp");
    rd(0, O_CTRL, 32'd0, "r_ctrl");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
